// File: rtl/pipe_stim_seq.sv
// Scripted reset/interrupt sequencer for the pipelined CPU: a timed reset pulse,
// then playback of up to DEPTH interrupt patterns, each held for a duration or until acked.
module pipe_stim_seq #(
  parameter int N_IRQ       = 2,
  parameter int ARG_W       = 6,
  parameter int ARG_DEFAULT = 60,
  parameter int DEPTH       = 8,
  parameter int DUR_W       = 16,
  parameter int RST_CYC     = 25,
  parameter int AW          = $clog2(DEPTH)
) (
  input  logic             clk_gl_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             mode_i,
  input  logic             loop_en_i,
  input  logic [AW:0]      n_steps_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [N_IRQ-1:0] wr_irq_i,
  input  logic [DUR_W-1:0] wr_dur_i,
  input  logic             arg_we_i,
  input  logic [ARG_W-1:0] arg_in_i,
  input  logic [N_IRQ-1:0] irq_ack_i,
  output logic             cpu_rst_o,
  output logic [N_IRQ-1:0] interrupt_o,
  output logic [ARG_W-1:0] arguments_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [AW-1:0]    step_idx_o
);

  localparam int CW = $clog2(RST_CYC + 1);

  typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic               loop_q, loop_d;
  logic [AW:0]        nsteps_q, nsteps_d;
  logic [CW-1:0]      rstCnt_q, rstCnt_d;
  logic [AW-1:0]      stepIdx_q, stepIdx_d;
  logic [DUR_W-1:0]   durCnt_q, durCnt_d;
  logic [N_IRQ-1:0]   irq_q, irq_d;
  logic               cpuRst_q, cpuRst_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ARG_W-1:0]   args_q;

  logic [N_IRQ-1:0]   memIrq [DEPTH];
  logic [DUR_W-1:0]   memDur [DEPTH];

  logic [N_IRQ-1:0]   maskNext;
  logic               timedOut, lastStep, stepEnd;
  logic [AW-1:0]      loadIdx;
  logic [N_IRQ-1:0]   entryIrq;
  logic [DUR_W-1:0]   entryDur, loadDur;

  // Script RAM has no reset; the busy guard keeps it stable during playback.
  always_ff @(posedge clk_gl_i) begin
    if (wr_en_i && !busy_q) begin
      memIrq[wr_addr_i] <= wr_irq_i;
      memDur[wr_addr_i] <= wr_dur_i;
    end
  end

  // The entry loaded at a step boundary is prefetched so steps run back-to-back;
  // durCnt of 0 only occurs in ack mode and means "no timeout".
  always_comb begin
    maskNext = irq_q & ~irq_ack_i;
    timedOut = (durCnt_q == DUR_W'(1));
    lastStep = ({1'b0, stepIdx_q} == nsteps_q - (AW+1)'(1));
    stepEnd  = mode_q ? (timedOut || (maskNext == '0)) : timedOut;
    loadIdx  = (state_q == RUN && !lastStep) ? stepIdx_q + AW'(1) : '0;
    entryIrq = memIrq[loadIdx];
    entryDur = memDur[loadIdx];
    loadDur  = (mode_q || entryDur != '0) ? entryDur : DUR_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    loop_d    = loop_q;
    nsteps_d  = nsteps_q;
    rstCnt_d  = rstCnt_q;
    stepIdx_d = stepIdx_q;
    durCnt_d  = durCnt_q;
    irq_d     = irq_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          mode_d    = mode_i;
          loop_d    = loop_en_i;
          nsteps_d  = n_steps_i;
          rstCnt_d  = CW'(RST_CYC);
          stepIdx_d = '0;
          irq_d     = '0;
          state_d   = RESET;
        end
      end
      RESET: begin
        rstCnt_d = rstCnt_q - CW'(1);
        if (rstCnt_q == CW'(1)) begin
          if (nsteps_q == '0) begin
            state_d = DONE;
          end else begin
            state_d   = RUN;
            stepIdx_d = '0;
            irq_d     = entryIrq;
            durCnt_d  = loadDur;
          end
        end
      end
      RUN: begin
        if (mode_q) irq_d = maskNext;
        if (durCnt_q != '0) durCnt_d = durCnt_q - DUR_W'(1);
        if (stepEnd) begin
          if (lastStep && !loop_q) begin
            state_d = DONE;
            irq_d   = '0;
          end else begin
            stepIdx_d = loadIdx;
            irq_d     = entryIrq;
            durCnt_d  = loadDur;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_i) begin
      state_d   = IDLE;
      irq_d     = '0;
      stepIdx_d = '0;
    end
    cpuRst_d = (state_d == RESET);
    busy_d   = (state_d == RESET) || (state_d == RUN);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk_gl_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      loop_q    <= 1'b0;
      nsteps_q  <= '0;
      rstCnt_q  <= '0;
      stepIdx_q <= '0;
      durCnt_q  <= '0;
      irq_q     <= '0;
      cpuRst_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      args_q    <= ARG_W'(ARG_DEFAULT);
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      loop_q    <= loop_d;
      nsteps_q  <= nsteps_d;
      rstCnt_q  <= rstCnt_d;
      stepIdx_q <= stepIdx_d;
      durCnt_q  <= durCnt_d;
      irq_q     <= irq_d;
      cpuRst_q  <= cpuRst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      if (arg_we_i) args_q <= arg_in_i;
    end
  end

  assign cpu_rst_o   = cpuRst_q;
  assign interrupt_o = irq_q;
  assign arguments_o = args_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign step_idx_o  = stepIdx_q;

endmodule

// File: tb/tb_pipe_stim_seq.sv
// Scoreboard bench for pipe_stim_seq: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them when that cycle comes round.
module tb_pipe_stim_seq;

  localparam int N_IRQ = 2, ARG_W = 6, DEPTH = 8, DUR_W = 16, RST_CYC = 25;
  localparam int AW = $clog2(DEPTH);
  localparam int SEL_RST = 0, SEL_IRQ = 1, SEL_ARG = 2, SEL_BUSY = 3, SEL_DONE = 4, SEL_IDX = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0, abort = 1'b0, mode = 1'b0, loopEn = 1'b0;
  logic [AW:0]      nSteps = '0;
  logic             wrEn = 1'b0;
  logic [AW-1:0]    wrAddr = '0;
  logic [N_IRQ-1:0] wrIrq = '0;
  logic [DUR_W-1:0] wrDur = '0;
  logic             argWe = 1'b0;
  logic [ARG_W-1:0] argIn = '0;
  logic [N_IRQ-1:0] irqAck = '0;
  logic             cpuRst, busy, done;
  logic [N_IRQ-1:0] interrupt;
  logic [ARG_W-1:0] arguments;
  logic [AW-1:0]    stepIdx;

  int edgeCnt = 0;
  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int cyc;
    int sel;
    int val;
  } exp_t;
  exp_t expQ[$];

  pipe_stim_seq dut (
    .clk_gl_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .mode_i(mode), .loop_en_i(loopEn), .n_steps_i(nSteps),
    .wr_en_i(wrEn), .wr_addr_i(wrAddr), .wr_irq_i(wrIrq), .wr_dur_i(wrDur),
    .arg_we_i(argWe), .arg_in_i(argIn), .irq_ack_i(irqAck),
    .cpu_rst_o(cpuRst), .interrupt_o(interrupt), .arguments_o(arguments),
    .busy_o(busy), .done_o(done), .step_idx_o(stepIdx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  function automatic string selName(input int sel);
    case (sel)
      SEL_RST:  return "cpu_rst";
      SEL_IRQ:  return "interrupt";
      SEL_ARG:  return "arguments";
      SEL_BUSY: return "busy";
      SEL_DONE: return "done";
      default:  return "step_idx";
    endcase
  endfunction

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      SEL_RST:  return {31'b0, cpuRst};
      SEL_IRQ:  return {{(32-N_IRQ){1'b0}}, interrupt};
      SEL_ARG:  return {{(32-ARG_W){1'b0}}, arguments};
      SEL_BUSY: return {31'b0, busy};
      SEL_DONE: return {31'b0, done};
      default:  return {{(32-AW){1'b0}}, stepIdx};
    endcase
  endfunction

  task automatic checkOutput(input exp_t e);
    logic [31:0] act;
    act = actual(e.sel);
    compared++;
    if (act !== 32'(e.val)) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", selName(e.sel), e.cyc, act, e.val);
    end
  endtask

  // Monitor: any expectation whose cycle has come is checked, stale ones are failures.
  always @(negedge clk) begin
    for (int i = expQ.size() - 1; i >= 0; i--) begin
      if (expQ[i].cyc == edgeCnt) begin
        checkOutput(expQ[i]);
        expQ.delete(i);
      end else if (expQ[i].cyc < edgeCnt) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL %s at cycle %0d: not sampled, expected %0d", selName(expQ[i].sel), expQ[i].cyc, expQ[i].val);
        expQ.delete(i);
      end
    end
  end

  task automatic expectAt(input int cyc, input int sel, input int val);
    exp_t e;
    e.cyc = cyc;
    e.sel = sel;
    e.val = val;
    expQ.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic waitUntil(input int e);
    while (edgeCnt < e) tick();
  endtask

  task automatic writeEntry(input int addr, input int irq, input int dur);
    wrEn = 1'b1;
    wrAddr = AW'(addr);
    wrIrq = N_IRQ'(irq);
    wrDur = DUR_W'(dur);
    tick();
    wrEn = 1'b0;
  endtask

  // Raises start; t is the edge that samples it. Caller queues expectations then drops start.
  task automatic applyStimulus(input logic m, input logic lp, input int n, output int t);
    mode = m;
    loopEn = lp;
    nSteps = (AW+1)'(n);
    start = 1'b1;
    t = edgeCnt + 1;
  endtask

  task automatic dropStart();
    tick();
    start = 1'b0;
  endtask

  initial begin
    int t;
    for (int c = 1; c <= 4; c++) begin
      expectAt(c, SEL_RST, 0);
      expectAt(c, SEL_IRQ, 0);
      expectAt(c, SEL_ARG, 60);
      expectAt(c, SEL_BUSY, 0);
      expectAt(c, SEL_DONE, 0);
      expectAt(c, SEL_IDX, 0);
    end
    waitUntil(3);
    rst = 1'b0;
    waitUntil(4);
    argWe = 1'b1;
    argIn = 6'd17;
    expectAt(5, SEL_ARG, 17);
    tick();
    argWe = 1'b0;

    // Timed playback with a zero-duration last entry.
    writeEntry(0, 2, 100);
    writeEntry(1, 0, 100);
    writeEntry(2, 1, 0);
    applyStimulus(1'b0, 1'b0, 3, t);
    expectAt(t, SEL_RST, 1);      expectAt(t, SEL_BUSY, 1);
    expectAt(t + 24, SEL_RST, 1); expectAt(t + 24, SEL_IRQ, 0);
    expectAt(t + 25, SEL_RST, 0); expectAt(t + 25, SEL_IRQ, 2); expectAt(t + 25, SEL_IDX, 0);
    expectAt(t + 100, SEL_ARG, 17);
    expectAt(t + 124, SEL_IRQ, 2);
    expectAt(t + 125, SEL_IRQ, 0); expectAt(t + 125, SEL_IDX, 1);
    expectAt(t + 224, SEL_IRQ, 0);
    expectAt(t + 225, SEL_IRQ, 1); expectAt(t + 225, SEL_IDX, 2); expectAt(t + 225, SEL_DONE, 0);
    expectAt(t + 226, SEL_IRQ, 0); expectAt(t + 226, SEL_DONE, 1); expectAt(t + 226, SEL_BUSY, 0);
    dropStart();
    waitUntil(t + 230);

    // Ack mode: bit0 acked, then bit1, then a zero pattern entry.
    writeEntry(0, 3, 0);
    writeEntry(1, 0, 0);
    applyStimulus(1'b1, 1'b0, 2, t);
    expectAt(t + 25, SEL_IRQ, 3); expectAt(t + 27, SEL_IRQ, 3);
    expectAt(t + 28, SEL_IRQ, 2); expectAt(t + 32, SEL_IRQ, 2); expectAt(t + 32, SEL_IDX, 0);
    expectAt(t + 33, SEL_IRQ, 0); expectAt(t + 33, SEL_IDX, 1); expectAt(t + 33, SEL_DONE, 0);
    expectAt(t + 34, SEL_DONE, 1); expectAt(t + 34, SEL_IRQ, 0);
    dropStart();
    waitUntil(t + 27);
    irqAck = 2'b01;
    tick();
    irqAck = 2'b00;
    waitUntil(t + 32);
    irqAck = 2'b10;
    tick();
    irqAck = 2'b00;
    waitUntil(t + 36);

    // Ack mode with no ack: timeout after 8 cycles.
    writeEntry(0, 3, 8);
    applyStimulus(1'b1, 1'b0, 1, t);
    expectAt(t + 25, SEL_IRQ, 3); expectAt(t + 32, SEL_IRQ, 3); expectAt(t + 32, SEL_DONE, 0);
    expectAt(t + 33, SEL_IRQ, 0); expectAt(t + 33, SEL_DONE, 1);
    dropStart();
    waitUntil(t + 36);

    // Loop wrap, then abort mid-run.
    writeEntry(0, 1, 3);
    writeEntry(1, 2, 2);
    applyStimulus(1'b0, 1'b1, 2, t);
    expectAt(t + 27, SEL_IDX, 0);
    expectAt(t + 28, SEL_IDX, 1); expectAt(t + 28, SEL_IRQ, 2);
    expectAt(t + 30, SEL_IDX, 0); expectAt(t + 30, SEL_IRQ, 1);
    expectAt(t + 33, SEL_IDX, 1);
    expectAt(t + 40, SEL_DONE, 0); expectAt(t + 40, SEL_BUSY, 1);
    dropStart();
    waitUntil(t + 40);
    abort = 1'b1;
    expectAt(t + 41, SEL_BUSY, 0); expectAt(t + 41, SEL_IRQ, 0); expectAt(t + 41, SEL_IDX, 0);
    expectAt(t + 41, SEL_RST, 0);  expectAt(t + 41, SEL_DONE, 0);
    expectAt(t + 45, SEL_BUSY, 0);
    tick();
    abort = 1'b0;
    waitUntil(t + 46);

    // Write while busy must not alter the playing script.
    writeEntry(0, 1, 5);
    applyStimulus(1'b0, 1'b0, 1, t);
    expectAt(t + 25, SEL_IRQ, 1); expectAt(t + 29, SEL_IRQ, 1);
    expectAt(t + 30, SEL_IRQ, 0); expectAt(t + 30, SEL_DONE, 1);
    dropStart();
    waitUntil(t + 2);
    writeEntry(0, 2, 5);
    waitUntil(t + 32);

    // n_steps = 0 from DONE: reset pulse straight into DONE.
    applyStimulus(1'b0, 1'b0, 0, t);
    expectAt(t, SEL_RST, 1);       expectAt(t, SEL_DONE, 0);
    expectAt(t + 24, SEL_RST, 1);  expectAt(t + 24, SEL_DONE, 0);
    expectAt(t + 25, SEL_RST, 0);  expectAt(t + 25, SEL_DONE, 1);
    expectAt(t + 25, SEL_BUSY, 0); expectAt(t + 25, SEL_IRQ, 0);
    dropStart();
    waitUntil(t + 28);

    // Synchronous reset during the CPU reset pulse.
    applyStimulus(1'b0, 1'b0, 1, t);
    expectAt(t + 5, SEL_RST, 1);
    dropStart();
    waitUntil(t + 5);
    rst = 1'b1;
    expectAt(t + 6, SEL_RST, 0);  expectAt(t + 6, SEL_BUSY, 0); expectAt(t + 6, SEL_ARG, 60);
    expectAt(t + 6, SEL_IDX, 0);  expectAt(t + 6, SEL_DONE, 0);
    expectAt(t + 30, SEL_RST, 0); expectAt(t + 30, SEL_BUSY, 0); expectAt(t + 30, SEL_IRQ, 0);
    tick();
    rst = 1'b0;
    waitUntil(t + 31);

    for (int i = 0; i < 20 && expQ.size() > 0; i++) tick();
    while (expQ.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: never checked, expected %0d", selName(expQ[0].sel), expQ[0].cyc, expQ[0].val);
      expQ.delete(0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
